// File: rtl/mux_scan_ctrl_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_scan_ctrl_pkg
// Shared definitions for the 4:1 mux scan controller:
//   - scan_state_e : FSM encodings (IDLE, SCAN, DONE)
//   - SEL_CHx      : {m,s} select pair for each mux channel (a..d)
//   - ch_sel()     : channel index -> {m,s}, the single source of channel order
// -----------------------------------------------------------------------------
package mux_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    localparam int unsigned NUM_CH = 4;
    localparam logic [1:0]  LAST_IDX = 2'(NUM_CH - 1);

    // {m,s} per channel, fixed by how the mux is wired
    localparam logic [1:0] SEL_CH0 = 2'b01;  // a
    localparam logic [1:0] SEL_CH1 = 2'b00;  // b
    localparam logic [1:0] SEL_CH2 = 2'b10;  // c
    localparam logic [1:0] SEL_CH3 = 2'b11;  // d

    function automatic logic [1:0] ch_sel(input logic [1:0] idx);
        logic [1:0] ms;
        case (idx)
            2'd0:    ms = SEL_CH0;
            2'd1:    ms = SEL_CH1;
            2'd2:    ms = SEL_CH2;
            default: ms = SEL_CH3;
        endcase
        return ms;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_scan_ctrl_if
// Handshake and mux-side signals of the scan controller.
//   start   : scan request (consumer -> controller)
//   mux_w   : mux output w (mux -> controller)
//   sel_s   : mux select s (controller -> mux)
//   sel_m   : mux select m (controller -> mux)
//   busy    : scan in progress
//   done    : one-cycle pulse when result updates
//   result  : {d,c,b,a} as sampled through the mux
// master = controller side, slave = requester/mux side.
// -----------------------------------------------------------------------------
interface mux_scan_ctrl_if;
    logic       start;
    logic       mux_w;
    logic       sel_s;
    logic       sel_m;
    logic       busy;
    logic       done;
    logic [3:0] result;

    modport master (
        input  start,
        input  mux_w,
        output sel_s,
        output sel_m,
        output busy,
        output done,
        output result
    );

    modport slave (
        output start,
        output mux_w,
        input  sel_s,
        input  sel_m,
        input  busy,
        input  done,
        input  result
    );
endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_scan_ctrl_settle_timer
// CW-bit settle counter. Counts while en_i is high, wraps to zero on its
// terminal count (SETTLE-1) so each channel gets exactly SETTLE cycles.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   clr_i : hold the counter at zero
//   en_i  : count enable
//   tc_o  : terminal-count flag (counter == SETTLE-1)
// -----------------------------------------------------------------------------
module mux_scan_ctrl_settle_timer #(
    parameter int unsigned SETTLE = 3,
    parameter int unsigned CW     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CW-1:0] TC_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (en_i && tc_o)) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Walks the 4:1 mux through channels a,b,c,d, holds each select pair for
// SETTLE cycles, samples mux_w at the end of each window and publishes the
// four samples as result = {d,c,b,a} with a start/busy/done handshake.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mux_scan_ctrl_if.master (start, mux_w, sel_s, sel_m, busy, done,
//         result)
// -----------------------------------------------------------------------------
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 3,
    parameter int unsigned CW     = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.master bus
);

    scan_state_e state_q;
    logic [1:0]  idx_q;
    logic [3:0]  result_q;
    logic        busy_q;
    logic        done_q;
    logic        sel_s_q;
    logic        sel_m_q;
    logic [2:0]  shadow;

    logic        timer_en;
    logic        timer_clr;
    logic        timer_tc;
    logic        sample_now;

    assign timer_en   = (state_q == ST_SCAN);
    assign timer_clr  = ~timer_en;
    assign sample_now = timer_en && timer_tc;

    mux_scan_ctrl_settle_timer #(
        .SETTLE (SETTLE),
        .CW     (CW)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (timer_clr),
        .en_i  (timer_en),
        .tc_o  (timer_tc)
    );

    // Shadow bits for channels a..c; channel d goes straight into result.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shadow
            logic bit_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bit_q <= 1'b0;
                end else if (sample_now && (idx_q == 2'(gi))) begin
                    bit_q <= bus.mux_w;
                end
            end
            assign shadow[gi] = bit_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= ST_IDLE;
            idx_q                <= 2'd0;
            result_q             <= 4'd0;
            busy_q               <= 1'b0;
            done_q               <= 1'b0;
            {sel_m_q, sel_s_q}   <= SEL_CH0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q            <= ST_SCAN;
                        idx_q              <= 2'd0;
                        busy_q             <= 1'b1;
                        {sel_m_q, sel_s_q} <= ch_sel(2'd0);
                    end
                end
                ST_SCAN: begin
                    if (timer_tc) begin
                        if (idx_q == LAST_IDX) begin
                            // Last channel: bypass the shadow so result and
                            // done appear on the same edge as the final sample.
                            result_q           <= {bus.mux_w, shadow};
                            state_q            <= ST_DONE;
                            idx_q              <= 2'd0;
                            busy_q             <= 1'b0;
                            done_q             <= 1'b1;
                            {sel_m_q, sel_s_q} <= ch_sel(2'd0);
                        end else begin
                            idx_q              <= idx_q + 2'd1;
                            {sel_m_q, sel_s_q} <= ch_sel(idx_q + 2'd1);
                        end
                    end
                end
                ST_DONE: begin
                    // start is deliberately ignored here
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel_s  = sel_s_q;
    assign bus.sel_m  = sel_m_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Two controllers (SETTLE=3 and SETTLE=1) each drive a behavioural 4:1 mux
// whose output lags its inputs by a transport delay (~24 ns "slow" or ~1 ns
// "fast"). Directed scans with hand-computed results.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    logic clk;
    logic rst;
    logic [3:0] data;       // {d,c,b,a}
    logic sel_dut;          // 0: SETTLE=3 controller, 1: SETTLE=1 controller
    logic use_slow1;        // mux delay seen by the SETTLE=1 controller
    logic [31:0] hist3;
    logic [31:0] hist1;
    int n_tests;
    int n_fail;

    logic [1:0] exp_sel [4];

    mux_scan_ctrl_if if3();
    mux_scan_ctrl_if if1();

    mux_scan_ctrl #(.SETTLE(3), .CW(4)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    mux_scan_ctrl #(.SETTLE(1), .CW(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mux wiring: (m,s) = 01->a, 00->b, 10->c, 11->d
    function automatic logic mux_fn(input logic m, input logic s, input logic [3:0] dv);
        logic r;
        case ({m, s})
            2'b01:   r = dv[0];
            2'b00:   r = dv[1];
            2'b10:   r = dv[2];
            default: r = dv[3];
        endcase
        return r;
    endfunction

    // Delay line updated on half-ns ticks so it never races a clock edge.
    initial begin
        hist3 = '0;
        hist1 = '0;
        #0.5;
        forever begin
            hist3 = {hist3[30:0], mux_fn(if3.sel_m, if3.sel_s, data)};
            hist1 = {hist1[30:0], mux_fn(if1.sel_m, if1.sel_s, data)};
            #1;
        end
    end

    assign if3.mux_w = hist3[24];
    assign if1.mux_w = use_slow1 ? hist1[24] : hist1[1];

    logic       obs_busy;
    logic       obs_done;
    logic [1:0] obs_sel;
    logic [3:0] obs_result;
    assign obs_busy   = sel_dut ? if1.busy   : if3.busy;
    assign obs_done   = sel_dut ? if1.done   : if3.done;
    assign obs_sel    = sel_dut ? {if1.sel_m, if1.sel_s} : {if3.sel_m, if3.sel_s};
    assign obs_result = sel_dut ? if1.result : if3.result;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel_dut) if1.start = v;
        else         if3.start = v;
    endtask

    // Called at a negedge; start is seen at the next posedge (T0).
    task automatic run_scan(input string name, input int settle,
                            input logic [3:0] exp_res, input logic [3:0] old_res,
                            input bit keep_start);
        int last;
        last = 4 * settle;
        drive_start(1'b1);
        @(negedge clk);
        if (!keep_start) drive_start(1'b0);
        for (int j = 0; j <= last; j++) begin
            if (j < last) begin
                chk({name, "_busy"}, 32'(obs_busy), 32'd1);
                chk({name, "_done"}, 32'(obs_done), 32'd0);
                chk({name, "_sel"}, 32'(obs_sel), 32'(exp_sel[j / settle]));
                chk({name, "_hold"}, 32'(obs_result), 32'(old_res));
            end else begin
                chk({name, "_dbusy"}, 32'(obs_busy), 32'd0);
                chk({name, "_dpulse"}, 32'(obs_done), 32'd1);
                chk({name, "_dsel"}, 32'(obs_sel), 32'b01);
                chk({name, "_result"}, 32'(obs_result), 32'(exp_res));
            end
            @(negedge clk);
        end
        chk({name, "_idle_busy"}, 32'(obs_busy), 32'd0);
        chk({name, "_idle_done"}, 32'(obs_done), 32'd0);
        $display("[TB] scan %s settle=%0d result=%b expected=%b", name, settle, obs_result, exp_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_sel   = '{2'b01, 2'b00, 2'b10, 2'b11};
        rst       = 1'b0;
        sel_dut   = 1'b0;
        use_slow1 = 1'b0;
        if3.start = 1'b0;
        if1.start = 1'b0;
        data      = 4'b1101;     // a=1 b=0 c=1 d=1

        // Reset asserted between edges must act immediately
        #12;
        rst = 1'b1;
        #1;
        chk("rst_sel_s", 32'(if3.sel_s), 32'd1);
        chk("rst_sel_m", 32'(if3.sel_m), 32'd0);
        chk("rst_busy", 32'(if3.busy), 32'd0);
        chk("rst_done", 32'(if3.done), 32'd0);
        chk("rst_result", 32'(if3.result), 32'd0);
        chk("rst1_result", 32'(if1.result), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] reset checked");

        // Full scan, SETTLE=3, slow mux
        run_scan("scan1", 3, 4'b1101, 4'b0000, 1'b0);

        // New inputs a=0 b=1 c=0 d=0
        data = 4'b0010;
        repeat (2) @(negedge clk);
        run_scan("scan2", 3, 4'b0010, 4'b1101, 1'b0);

        // start held high across two scans
        data = 4'b1101;
        repeat (2) @(negedge clk);
        run_scan("held1", 3, 4'b1101, 4'b0010, 1'b1);
        data = 4'b0110;          // a=0 b=1 c=1 d=0
        run_scan("held2", 3, 4'b0110, 4'b1101, 1'b1);
        drive_start(1'b0);
        @(negedge clk);
        chk("held_stop_busy", 32'(obs_busy), 32'd0);
        repeat (2) @(negedge clk);

        // Reset five cycles into a scan
        data = 4'b0111;          // a=1 b=1 c=1 d=0
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        repeat (5) @(negedge clk);
        chk("midrst_pre_busy", 32'(obs_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(obs_busy), 32'd0);
        chk("midrst_done", 32'(obs_done), 32'd0);
        chk("midrst_result", 32'(obs_result), 32'd0);
        chk("midrst_sel", 32'(obs_sel), 32'b01);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(obs_busy), 32'd0);
            chk("post_rst_done", 32'(obs_done), 32'd0);
        end
        $display("[TB] mid-scan reset checked");
        run_scan("after_rst", 3, 4'b0111, 4'b0000, 1'b0);

        // SETTLE=1 with a fast mux
        sel_dut   = 1'b1;
        use_slow1 = 1'b0;
        data      = 4'b0011;     // a=1 b=1 c=0 d=0
        repeat (4) @(negedge clk);
        run_scan("s1_fast", 1, 4'b0011, 4'b0000, 1'b0);

        // SETTLE=1 against the slow mux: samples lag, giving {b,a,a,a}
        use_slow1 = 1'b1;
        repeat (5) @(negedge clk);
        run_scan("s1_slow", 1, 4'b1111, 4'b0011, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
